// File: rtl/cmp_pkg.sv
// Shared result encoding and FSM state type for the serial word comparator.
package cmp_pkg;
  localparam logic [1:0] CMP_LT = 2'd0;
  localparam logic [1:0] CMP_GT = 2'd1;
  localparam logic [1:0] CMP_EQ = 2'd2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_CMP  = 1'b1
  } state_e;
endpackage

// File: rtl/nib_cmp.sv
// Combinational 4-bit unsigned magnitude compare using the cmp_pkg encoding.
module nib_cmp
  import cmp_pkg::*;
(
  input  logic [3:0] x,
  input  logic [3:0] y,
  output logic [1:0] r
);
  always_comb begin
    if (x > y)      r = CMP_GT;
    else if (x < y) r = CMP_LT;
    else            r = CMP_EQ;
  end
endmodule

// File: rtl/serial_word_cmp_ctrl.sv
// Sequences a wide compare through one nibble comparator, MSB first, stopping early.
// Optional macro SERIAL_CMP_SIGNED_EN: two's-complement operands.
module serial_word_cmp_ctrl
  import cmp_pkg::*;
#(
  parameter  int NIBBLES = 4,
  localparam int W       = 4 * NIBBLES,
  localparam int CW      = $clog2(NIBBLES + 1),
  localparam int IW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  output logic          busy,
  output logic          done,
  output logic [1:0]    result,
  output logic [CW-1:0] ncmp
);
  state_e        state_q, state_d;
  logic [W-1:0]  sa_q, sa_d, sb_q, sb_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    result_q, result_d;
  logic [CW-1:0] ncmp_q, ncmp_d;
  logic          done_q, done_d;

  logic [3:0] nx, ny;
  logic [1:0] nr;

  always_comb begin
    nx = sa_q[W-1 -: 4];
    ny = sb_q[W-1 -: 4];
`ifdef SERIAL_CMP_SIGNED_EN
    // Flipping both sign bits on the top nibble turns signed order into unsigned order.
    if (cnt_q == '0) begin
      nx[3] = ~nx[3];
      ny[3] = ~ny[3];
    end
`endif
  end

  nib_cmp u_nib_cmp (
    .x (nx),
    .y (ny),
    .r (nr)
  );

  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    ncmp_d   = ncmp_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          idx_d   = IW'(NIBBLES - 1);
          cnt_d   = '0;
          state_d = ST_CMP;
        end
      end
      ST_CMP: begin
        if (nr != CMP_EQ) begin
          result_d = nr;
          ncmp_d   = cnt_q + CW'(1);
          done_d   = 1'b1;
          state_d  = ST_IDLE;
        end else if (idx_q == '0) begin
          result_d = CMP_EQ;
          ncmp_d   = CW'(NIBBLES);
          done_d   = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          sa_d  = sa_q << 4;
          sb_d  = sb_q << 4;
          idx_d = idx_q - IW'(1);
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      result_q <= CMP_EQ;
      ncmp_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      ncmp_q   <= ncmp_d;
      done_q   <= done_d;
    end
  end

  assign busy   = (state_q == ST_CMP);
  assign done   = done_q;
  assign result = result_q;
  assign ncmp   = ncmp_q;
endmodule

// File: doc/serial_word_cmp_ctrl.md
Name: serial_word_cmp_ctrl

Overview:
- Sequencer that compares two wide unsigned words by driving one 4-bit nibble comparator, MSB nibble first, one nibble per clock.
- Stops early on the first unequal nibble.
- Sits between a requesting datapath (ALU, sorter, branch unit) and the shared nibble-compare resource.
- Uses a start/busy/done handshake, so wide compares cost no wide comparator logic.

Parameters:
- NIBBLES, 4, number of 4-bit nibbles per operand; operand width W = 4*NIBBLES; legal range 1..16.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only when busy=0
- a  in  W  operand A; sampled on the accepting edge only
- b  in  W  operand B; sampled on the accepting edge only
- busy  out  1  compare in progress
- done  out  1  one-cycle pulse: result and ncmp are valid
- result  out  2  2'd1 A>B, 2'd0 A<B, 2'd2 A==B; held until the next done
- ncmp  out  $clog2(NIBBLES+1)  nibbles examined for the last result; held

Behaviour:
- Reset (asynchronous, any time, including mid-compare): state IDLE, busy=0, done=0, result=2'd2, ncmp=0, shift registers cleared.
- States: IDLE, CMP.
- IDLE: start=1 at an edge latches a and b into shift registers sa and sb, sets idx=NIBBLES-1 and cnt=0, then goes to CMP. busy rises after that edge.
- CMP, each cycle:
  - The nibble comparator sees sa[W-1:W-4] and sb[W-1:W-4].
  - Unequal: at the next edge, result = comparator output, ncmp = cnt+1, done=1, busy=0, go to IDLE.
  - Equal with idx==0: same, except result=2'd2 and ncmp=NIBBLES.
  - Equal otherwise: shift sa and sb left by 4, idx-1, cnt+1.
- Latency: if the first differing nibble is the k-th from the MSB (k=1..NIBBLES), done goes high k cycles after the accepting edge. Equal operands take NIBBLES cycles.
- done is high for exactly one cycle.
- start while busy=1 is ignored. The operands are not re-sampled and no queueing happens.
- start high in the same cycle as done is accepted, because state is already IDLE. This gives back-to-back compares with no bubble.
- a and b may change freely after the accepting edge.
- result and ncmp change only on the done edge or on reset.
- NIBBLES=1: a single CMP cycle; ncmp is always 1.

Optional Feature:
- Macro SERIAL_CMP_SIGNED_EN.
- Defined: operands are two's complement. During the first CMP cycle only (cnt==0), bit 3 of both comparator inputs is inverted, so the sign bits compare inverted. All later nibbles compare unsigned. Encoding and latency are unchanged.
- Undefined: pure unsigned compare, and no inversion logic is generated.

Decomposition:
- Shared package cmp_pkg holds:
  - result encoding constants CMP_LT=2'd0, CMP_GT=2'd1, CMP_EQ=2'd2;
  - state type with values ST_IDLE and ST_CMP.
- One sub-module, nib_cmp: a combinational 4-bit compare with inputs x[3:0] and y[3:0] and output r[1:0] using the cmp_pkg encoding, instantiated once.
- The controller holds the FSM, the shift registers, idx/cnt and the output registers.

Test Plan (NIBBLES=4):
- MSB differs: a=16'h1234, b=16'h0234 -> done 1 cycle after accept, result=1, ncmp=1; busy high for 1 cycle.
- LSB differs: a=16'h1233, b=16'h1234 -> done 4 cycles after accept, result=0, ncmp=4.
- Equal: a=b=16'hABCD -> result=2, ncmp=4. Then a=16'h0000, b=16'hFFFF -> result=0, ncmp=1.
- Handshake:
  - start pulsed on cycle 2 of a busy compare with different operands -> ignored; the first result is unchanged.
  - start held high through done -> a second compare is accepted on the done edge with no idle cycle.
- Reset mid-compare: rst_n low during cycle 2 of a=16'h1110, b=16'h1111 -> busy=0, done=0, result=2, ncmp=0 immediately (asynchronous). After release, a new start completes normally.
- With SERIAL_CMP_SIGNED_EN:
  - a=16'h8000, b=16'h0001 -> result=0 (unsigned build gives 1).
  - a=16'hFFFF, b=16'hFFFE -> result=1, ncmp=4.
